// File: rtl/cached_mem_ctrl_if.sv
// Bus interface for cached_mem_ctrl: CPU request/response channel plus backing-memory channel.
// The controller uses the slave modport; the CPU/memory side uses master.
interface cached_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cached_mem_ctrl.sv
// Direct-mapped, write-through cache controller with CPU valid/ready and memory req/ack handshakes.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cached_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  cached_mem_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, RESP} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  logic [IDX_W-1:0]      req_idx, cap_idx, line_idx;
  logic [TAG_W-1:0]      req_tag, cap_tag, line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_we, flush_all, hit, accept;

  assign req_idx = bus.req_addr[IDX_W-1:0];
  assign req_tag = bus.req_addr[ADDR_WIDTH-1:IDX_W];
  assign cap_idx = mem_addr_q[IDX_W-1:0];
  assign cap_tag = mem_addr_q[ADDR_WIDTH-1:IDX_W];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign bus.req_ready  = (state_q == IDLE) && !flush && !reset;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  // A single line write port serves both the write-hit update and the miss refill.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    line_we      = 1'b0;
    line_idx     = req_idx;
    line_tag     = req_tag;
    line_data    = bus.req_wdata;
    flush_all    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (accept) begin
          mem_addr_d = bus.req_addr;
          if (bus.req_write) begin
            line_we     = hit;
            state_d     = WR_MEM;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else if (hit) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = data_q[req_idx];
          end else begin
            state_d     = RD_MISS;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end
      RD_MISS: begin
        if (bus.mem_ack) begin
          line_we      = 1'b1;
          line_idx     = cap_idx;
          line_tag     = cap_tag;
          line_data    = bus.mem_rdata;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus.mem_rdata;
          mem_req_d    = 1'b0;
        end
      end
      WR_MEM: begin
        if (bus.mem_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          mem_req_d    = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag and data arrays are deliberately left uncleared by reset; only valid bits are.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      if (flush_all) begin
        valid_q <= '0;
      end else if (line_we) begin
        valid_q[line_idx] <= 1'b1;
      end
      if (line_we) begin
        tag_q[line_idx]  <= line_tag;
        data_q[line_idx] <= line_data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (accept && !bus.req_write) begin
      if (hit) hit_count_d = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule
